// File: rtl/matmul_tile_scheduler_pkg.sv
`default_nettype none
// ============================================================================
// Module   : matmul_tile_scheduler_pkg
// Brief    : Shared types and width helpers for the matmul tile scheduler.
// Revision : 1.0 - initial release
// ============================================================================
package matmul_tile_scheduler_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLEAR = 3'd1,
        FEED  = 3'd2,
        WAIT  = 3'd3,
        OUT   = 3'd4,
        DONE  = 3'd5
    } sched_state_t;

    localparam int c_PERF_WIDTH = 32;

    function automatic int k_beats(input int inner_dim, input int block_size);
        return inner_dim / block_size;
    endfunction

    // Index width that never collapses to zero bits for single-entry ranges.
    function automatic int clog2_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage
`default_nettype wire

// File: rtl/matmul_tile_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module   : matmul_tile_scheduler_if
// Brief    : Control, operand-buffer and result handshake bundle of the scheduler.
//            Perf counter signals exist only when MATMUL_SCHED_PERF_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
interface matmul_tile_scheduler_if #(
    parameter int ADDR_WIDTH = 10,
    parameter int ROW_W      = 2,
    parameter int COL_W      = 2
);
    logic                  start;
    logic                  busy;
    logic                  done;
    logic                  rd_en;
    logic [ADDR_WIDTH-1:0] addr_n;
    logic [ADDR_WIDTH-1:0] addr_w;
    logic                  core_en;
    logic                  core_reset_acc;
    logic                  acc_done;
    logic                  sys_finish;
    logic                  out_valid;
    logic                  out_ready;
    logic [ROW_W-1:0]      out_row;
    logic [COL_W-1:0]      out_col;
    logic                  err;
`ifdef MATMUL_SCHED_PERF_EN
    logic [31:0]           perf_cycles;
    logic [31:0]           perf_stall;
`endif

    modport master (
        input  start, acc_done, sys_finish, out_ready,
`ifdef MATMUL_SCHED_PERF_EN
        output perf_cycles, perf_stall,
`endif
        output busy, done, rd_en, addr_n, addr_w, core_en, core_reset_acc,
               out_valid, out_row, out_col, err
    );

    modport slave (
        output start, acc_done, sys_finish, out_ready,
`ifdef MATMUL_SCHED_PERF_EN
        input  perf_cycles, perf_stall,
`endif
        input  busy, done, rd_en, addr_n, addr_w, core_en, core_reset_acc,
               out_valid, out_row, out_col, err
    );

endinterface
`default_nettype wire

// File: rtl/matmul_tile_scheduler_tile_counter.sv
`default_nettype none
// ============================================================================
// Module   : matmul_tile_scheduler_tile_counter
// Brief    : Modulo-MODULUS counter with increment, clear and terminal-count flag.
// Revision : 1.0 - initial release
// ============================================================================
module matmul_tile_scheduler_tile_counter #(
    parameter int MODULUS = 2,
    parameter int WIDTH   = 1
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             i_inc,
    input  wire logic             i_clr,
    output logic      [WIDTH-1:0] o_count,
    output logic                  o_wrap
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_count <= '0;
        end else if (i_inc) begin
            r_count <= o_wrap ? '0 : r_count + 1'b1;
        end
    end

    assign o_count = r_count;
    assign o_wrap  = (r_count == WIDTH'(MODULUS - 1));

endmodule
`default_nettype wire

// File: rtl/matmul_tile_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : matmul_tile_scheduler
// Brief    : Sequences clear/feed/wait/handoff of every tile of a tiled matmul
//            on the systolic array. Define MATMUL_SCHED_PERF_EN for perf counters.
// Revision : 1.0 - initial release
// ============================================================================
module matmul_tile_scheduler
    import matmul_tile_scheduler_pkg::*;
#(
    parameter int BLOCK_SIZE      = 2,
    parameter int INNER_DIMENSION = 64,
    parameter int NUM_CORES       = 2,
    parameter int ROW_GROUPS      = 4,
    parameter int COL_TILES       = 4,
    parameter int ADDR_WIDTH      = 10
) (
    input wire logic                clk,
    input wire logic                rst,
    matmul_tile_scheduler_if.master sched
);

    localparam int c_K_BEATS = k_beats(INNER_DIMENSION, BLOCK_SIZE);
    localparam int c_K_W     = clog2_w(c_K_BEATS);
    localparam int c_ROW_W   = clog2_w(ROW_GROUPS);
    localparam int c_COL_W   = clog2_w(COL_TILES);

    sched_state_t r_state;
    sched_state_t w_next;

    logic               w_busy;
    logic               w_done;
    logic               w_rd_en;
    logic               w_reset_acc;
    logic               w_out_valid;
    logic               w_k_inc;
    logic               w_tile_inc;
    logic               w_cnt_clr;
    logic               r_core_en;
    logic               r_err;

    logic [c_K_W-1:0]   w_k;
    logic [c_ROW_W-1:0] w_row;
    logic [c_COL_W-1:0] w_col;
    logic               w_k_wrap;
    logic               w_row_wrap;
    logic               w_col_wrap;

    logic [ADDR_WIDTH-1:0] w_addr_n;
    logic [ADDR_WIDTH-1:0] w_addr_w;
    logic                  w_unused;

    // ------------------------------------------------------------------------
    // Beat / tile counters
    // ------------------------------------------------------------------------
    matmul_tile_scheduler_tile_counter #(.MODULUS(c_K_BEATS), .WIDTH(c_K_W)) u_k_cnt (
        .clk     (clk),
        .rst     (rst),
        .i_inc   (w_k_inc),
        .i_clr   (w_cnt_clr),
        .o_count (w_k),
        .o_wrap  (w_k_wrap)
    );

    matmul_tile_scheduler_tile_counter #(.MODULUS(COL_TILES), .WIDTH(c_COL_W)) u_col_cnt (
        .clk     (clk),
        .rst     (rst),
        .i_inc   (w_tile_inc),
        .i_clr   (w_cnt_clr),
        .o_count (w_col),
        .o_wrap  (w_col_wrap)
    );

    matmul_tile_scheduler_tile_counter #(.MODULUS(ROW_GROUPS), .WIDTH(c_ROW_W)) u_row_cnt (
        .clk     (clk),
        .rst     (rst),
        .i_inc   (w_tile_inc && w_col_wrap),
        .i_clr   (w_cnt_clr),
        .o_count (w_row),
        .o_wrap  (w_row_wrap)
    );

    // ------------------------------------------------------------------------
    // Sequencer
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next      = r_state;
        w_busy      = 1'b0;
        w_done      = 1'b0;
        w_rd_en     = 1'b0;
        w_reset_acc = 1'b0;
        w_out_valid = 1'b0;
        w_k_inc     = 1'b0;
        w_tile_inc  = 1'b0;
        w_cnt_clr   = 1'b0;
        case (r_state)
            IDLE: begin
                if (sched.start) begin
                    w_next    = CLEAR;
                    w_cnt_clr = 1'b1;
                end
            end
            CLEAR: begin
                w_busy      = 1'b1;
                w_reset_acc = 1'b1;
                w_next      = FEED;
            end
            FEED: begin
                w_busy  = 1'b1;
                w_rd_en = 1'b1;
                w_k_inc = 1'b1;
                if (w_k_wrap) begin
                    w_next = WAIT;
                end
            end
            WAIT: begin
                w_busy = 1'b1;
                if (sched.acc_done) begin
                    w_next = OUT;
                end
            end
            OUT: begin
                w_busy      = 1'b1;
                w_out_valid = 1'b1;
                if (sched.out_ready) begin
                    w_tile_inc = 1'b1;
                    w_next     = (w_row_wrap && w_col_wrap) ? DONE : CLEAR;
                end
            end
            DONE: begin
                w_done = 1'b1;
                w_next = IDLE;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    // Operand buffers have one cycle of read latency, so the array enable trails rd_en.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_core_en <= 1'b0;
        end else begin
            r_core_en <= w_rd_en;
        end
    end

    // An early acc_done means the array and sequencer disagree on tile boundaries.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_err <= 1'b0;
        end else if (sched.acc_done && ((r_state == FEED) || (r_state == CLEAR))) begin
            r_err <= 1'b1;
        end
    end

    assign w_addr_n = ADDR_WIDTH'(w_col) * ADDR_WIDTH'(c_K_BEATS) + ADDR_WIDTH'(w_k);
    assign w_addr_w = ADDR_WIDTH'(w_row) * ADDR_WIDTH'(c_K_BEATS) + ADDR_WIDTH'(w_k);

    assign sched.busy           = w_busy;
    assign sched.done           = w_done;
    assign sched.rd_en          = w_rd_en;
    assign sched.addr_n         = w_rd_en ? w_addr_n : '0;
    assign sched.addr_w         = w_rd_en ? w_addr_w : '0;
    assign sched.core_en        = r_core_en;
    assign sched.core_reset_acc = w_reset_acc;
    assign sched.out_valid      = w_out_valid;
    assign sched.out_row        = w_out_valid ? w_row : '0;
    assign sched.out_col        = w_out_valid ? w_col : '0;
    assign sched.err            = r_err;

    assign w_unused = &{1'b0, sched.sys_finish, NUM_CORES[0]};

`ifdef MATMUL_SCHED_PERF_EN
    logic [c_PERF_WIDTH-1:0] r_perf_cycles;
    logic [c_PERF_WIDTH-1:0] r_perf_stall;

    always_ff @(posedge clk) begin
        if (rst || ((r_state == IDLE) && sched.start)) begin
            r_perf_cycles <= '0;
            r_perf_stall  <= '0;
        end else begin
            if (w_busy && (r_perf_cycles != '1)) begin
                r_perf_cycles <= r_perf_cycles + 1'b1;
            end
            if ((r_state == OUT) && !sched.out_ready && (r_perf_stall != '1)) begin
                r_perf_stall <= r_perf_stall + 1'b1;
            end
        end
    end

    assign sched.perf_cycles = r_perf_cycles;
    assign sched.perf_stall  = r_perf_stall;
`endif

endmodule
`default_nettype wire
